// File: rtl/pulse_param_scheduler.sv
// Double-buffered pulse-timing parameter bank with commit-on-period-start and an
// optional delay sweep that steps the active delay after a fixed number of shots.
`timescale 1ns/1ps
module pulse_param_scheduler #(
    parameter logic [7:0]  DEF_PER    = 8'd1,
    parameter logic [15:0] DEF_P1     = 16'd30,
    parameter logic [15:0] DEF_DEL    = 16'd200,
    parameter logic [15:0] DEF_P2     = 16'd30,
    parameter logic [7:0]  DEF_CP     = 8'd3,
    parameter logic [7:0]  DEF_PBL    = 8'd50,
    parameter logic [15:0] DEF_PBLOFF = 16'd100,
    parameter logic [2:0]  DEF_FLAGS  = 3'b011,
    parameter logic [31:0] DEF_NUTW   = 32'd50,
    parameter logic [31:0] DEF_NUTD   = 32'd300
) (
    input  logic        clk_pll,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        period_start,
    output logic [7:0]  per,
    output logic [15:0] p1wid,
    output logic [15:0] del,
    output logic [15:0] p2wid,
    output logic [7:0]  cp,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic [31:0] nut_w,
    output logic [31:0] nut_d,
    output logic        pu,
    output logic        bl,
    output logic        nut,
    output logic        busy,
    output logic        commit_done,
    output logic        sweep_done,
    output logic [15:0] point_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    state_t      r_state;

    // Shadow bank, written by the host
    logic [7:0]  r_sh_per;
    logic [15:0] r_sh_p1;
    logic [15:0] r_sh_del;
    logic [15:0] r_sh_p2;
    logic [31:0] r_sh_nutw;
    logic [31:0] r_sh_nutd;
    logic [7:0]  r_sh_cp;
    logic [7:0]  r_sh_pbl;
    logic [15:0] r_sh_pbloff;
    logic [2:0]  r_sh_flags;
    logic [15:0] r_sh_step;
    logic [15:0] r_sh_shots;
    logic [15:0] r_sh_points;

    // Active bank, drives the pulse generator
    logic [7:0]  r_per;
    logic [15:0] r_p1;
    logic [15:0] r_del;
    logic [15:0] r_p2;
    logic [31:0] r_nutw;
    logic [31:0] r_nutd;
    logic [7:0]  r_cp;
    logic [7:0]  r_pbl;
    logic [15:0] r_pbloff;
    logic [2:0]  r_flags;

    // Sweep settings captured at commit, plus progress counters
    logic [15:0] r_sw_step;
    logic [15:0] r_sw_shots;
    logic [15:0] r_sw_points;
    logic [15:0] r_shot_cnt;
    logic [15:0] r_point_idx;
    logic        r_sw_en;

    logic        r_busy;
    logic        r_wr_ready;
    logic        r_commit_done;
    logic        r_sweep_done;

    logic        w_wr_fire;
    logic        w_commit;
    logic [15:0] w_shots_eff;
    logic        w_last_shot;
    logic [15:0] w_point_next;

    assign w_wr_fire    = wr_valid && r_wr_ready;
    assign w_commit     = w_wr_fire && (wr_addr == 4'hF);
    assign w_shots_eff  = (r_sw_shots == 16'd0) ? 16'd1 : r_sw_shots;
    assign w_last_shot  = (r_shot_cnt == (w_shots_eff - 16'd1));
    assign w_point_next = r_point_idx + 16'd1;

    // Shadow register writes; addresses D, E and the commit address store nothing here
    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            r_sh_per    <= DEF_PER;
            r_sh_p1     <= DEF_P1;
            r_sh_del    <= DEF_DEL;
            r_sh_p2     <= DEF_P2;
            r_sh_nutw   <= DEF_NUTW;
            r_sh_nutd   <= DEF_NUTD;
            r_sh_cp     <= DEF_CP;
            r_sh_pbl    <= DEF_PBL;
            r_sh_pbloff <= DEF_PBLOFF;
            r_sh_flags  <= DEF_FLAGS;
            r_sh_step   <= 16'd0;
            r_sh_shots  <= 16'd0;
            r_sh_points <= 16'd0;
        end else if (w_wr_fire) begin
            case (wr_addr)
                4'h0:    r_sh_per    <= wr_data[7:0];
                4'h1:    r_sh_p1     <= wr_data[15:0];
                4'h2:    r_sh_del    <= wr_data[15:0];
                4'h3:    r_sh_p2     <= wr_data[15:0];
                4'h4:    r_sh_nutw   <= wr_data;
                4'h5:    r_sh_nutd   <= wr_data;
                4'h6:    r_sh_cp     <= wr_data[7:0];
                4'h7:    r_sh_pbl    <= wr_data[7:0];
                4'h8:    r_sh_pbloff <= wr_data[15:0];
                4'h9:    r_sh_flags  <= wr_data[2:0];
                4'hA:    r_sh_step   <= wr_data[15:0];
                4'hB:    r_sh_shots  <= wr_data[15:0];
                4'hC:    r_sh_points <= wr_data[15:0];
                default: ;
            endcase
        end else begin
            r_sh_per <= r_sh_per;
        end
    end

    // Control FSM: arming, shadow-to-active commit and delay sweep stepping
    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_per         <= DEF_PER;
            r_p1          <= DEF_P1;
            r_del         <= DEF_DEL;
            r_p2          <= DEF_P2;
            r_nutw        <= DEF_NUTW;
            r_nutd        <= DEF_NUTD;
            r_cp          <= DEF_CP;
            r_pbl         <= DEF_PBL;
            r_pbloff      <= DEF_PBLOFF;
            r_flags       <= DEF_FLAGS;
            r_sw_step     <= 16'd0;
            r_sw_shots    <= 16'd0;
            r_sw_points   <= 16'd0;
            r_shot_cnt    <= 16'd0;
            r_point_idx   <= 16'd0;
            r_sw_en       <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_ready    <= 1'b1;
            r_commit_done <= 1'b0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_commit_done <= 1'b0;
            r_sweep_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_commit) begin
                        r_state    <= ST_ARMED;
                        r_sw_en    <= wr_data[0];
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (period_start) begin
                        r_per         <= r_sh_per;
                        r_p1          <= r_sh_p1;
                        r_del         <= r_sh_del;
                        r_p2          <= r_sh_p2;
                        r_nutw        <= r_sh_nutw;
                        r_nutd        <= r_sh_nutd;
                        r_cp          <= r_sh_cp;
                        r_pbl         <= r_sh_pbl;
                        r_pbloff      <= r_sh_pbloff;
                        r_flags       <= r_sh_flags;
                        r_sw_step     <= r_sh_step;
                        r_sw_shots    <= r_sh_shots;
                        r_sw_points   <= r_sh_points;
                        r_shot_cnt    <= 16'd0;
                        r_point_idx   <= 16'd0;
                        r_commit_done <= 1'b1;
                        r_wr_ready    <= 1'b1;
                        if (r_sw_en && (r_sh_points != 16'd0)) begin
                            r_state <= ST_SWEEP;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_SWEEP: begin
                    // A fresh commit abandons the sweep silently
                    if (w_commit) begin
                        r_state    <= ST_ARMED;
                        r_sw_en    <= wr_data[0];
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end else if (period_start) begin
                        if (w_last_shot) begin
                            r_shot_cnt  <= 16'd0;
                            r_del       <= r_del + r_sw_step;
                            r_point_idx <= w_point_next;
                            if (w_point_next == r_sw_points) begin
                                r_state      <= ST_IDLE;
                                r_busy       <= 1'b0;
                                r_sweep_done <= 1'b1;
                            end else begin
                                r_state <= ST_SWEEP;
                            end
                        end else begin
                            r_shot_cnt <= r_shot_cnt + 16'd1;
                        end
                    end else begin
                        r_state <= ST_SWEEP;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign per         = r_per;
    assign p1wid       = r_p1;
    assign del         = r_del;
    assign p2wid       = r_p2;
    assign cp          = r_cp;
    assign p_bl        = r_pbl;
    assign p_bl_off    = r_pbloff;
    assign nut_w       = r_nutw;
    assign nut_d       = r_nutd;
    assign nut         = r_flags[2];
    assign bl          = r_flags[1];
    assign pu          = r_flags[0];
    assign busy        = r_busy;
    assign wr_ready    = r_wr_ready;
    assign commit_done = r_commit_done;
    assign sweep_done  = r_sweep_done;
    assign point_idx   = r_point_idx;

endmodule

// File: tb/tb_pulse_param_scheduler.sv
// Directed bench for pulse_param_scheduler: defaults, commit timing, ready
// back-pressure, delay sweep with wrap, sweep abort and reset mid-sweep.
`timescale 1ns/1ps
module tb_pulse_param_scheduler;

    logic        clk_pll = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic        period_start = 1'b0;
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic [31:0] nut_w;
    logic [31:0] nut_d;
    logic        pu;
    logic        bl;
    logic        nut;
    logic        busy;
    logic        commit_done;
    logic        sweep_done;
    logic [15:0] point_idx;

    int n_vec = 0;
    int n_bad = 0;

    pulse_param_scheduler dut (
        .clk_pll(clk_pll), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .period_start(period_start),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .cp(cp),
        .p_bl(p_bl), .p_bl_off(p_bl_off), .nut_w(nut_w), .nut_d(nut_d),
        .pu(pu), .bl(bl), .nut(nut), .busy(busy),
        .commit_done(commit_done), .sweep_done(sweep_done), .point_idx(point_idx)
    );

    always #2.5 clk_pll = ~clk_pll;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("write_ready_timeout", 32'd0, 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pstart();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    initial begin
        // Reset and defaults
        repeat (3) @(posedge clk_pll);
        #1 reset = 1'b0;
        tick();
        chk("rst_per", {24'd0, per}, 32'd1);
        chk("rst_p1wid", {16'd0, p1wid}, 32'd30);
        chk("rst_del", {16'd0, del}, 32'd200);
        chk("rst_p2wid", {16'd0, p2wid}, 32'd30);
        chk("rst_cp", {24'd0, cp}, 32'd3);
        chk("rst_p_bl", {24'd0, p_bl}, 32'd50);
        chk("rst_p_bl_off", {16'd0, p_bl_off}, 32'd100);
        chk("rst_flags", {29'd0, nut, bl, pu}, 32'd3);
        chk("rst_nut_w", nut_w, 32'd50);
        chk("rst_nut_d", nut_d, 32'd300);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_dones", {30'd0, commit_done, sweep_done}, 32'd0);

        // Shadow write without commit leaves active untouched
        write(4'h2, 32'd500);
        pstart(); pstart(); pstart();
        chk("nocommit_del", {16'd0, del}, 32'd200);

        // Write coinciding with period_start in IDLE only reaches shadow
        wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 32'h0001_0028;
        period_start = 1'b1;
        tick();
        wr_valid = 1'b0; period_start = 1'b0;
        chk("same_edge_p2wid", {16'd0, p2wid}, 32'd30);

        // Commit arms; ready drops while armed
        write(4'hF, 32'd0);
        chk("armed_busy", {31'd0, busy}, 32'd1);
        chk("armed_ready", {31'd0, wr_ready}, 32'd0);

        // Held write must wait until the commit applies
        wr_valid = 1'b1; wr_addr = 4'h1; wr_data = 32'd77;
        tick();
        chk("armed_hold_ready", {31'd0, wr_ready}, 32'd0);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        chk("commit_del", {16'd0, del}, 32'd500);
        chk("commit_p2wid", {16'd0, p2wid}, 32'd40);
        chk("commit_done_hi", {31'd0, commit_done}, 32'd1);
        chk("commit_busy_lo", {31'd0, busy}, 32'd0);
        chk("commit_p1wid_old", {16'd0, p1wid}, 32'd30);
        tick();
        wr_valid = 1'b0;
        chk("commit_done_lo", {31'd0, commit_done}, 32'd0);
        chk("held_write_shadow_only", {16'd0, p1wid}, 32'd30);
        write(4'hD, 32'd123);
        write(4'hF, 32'd0);
        pstart();
        chk("held_write_applied", {16'd0, p1wid}, 32'd77);
        chk("ignored_addr_del", {16'd0, del}, 32'd500);

        // Sweep: step 10, 2 shots, 3 points from del 100
        write(4'hA, 32'd10);
        write(4'hB, 32'd2);
        write(4'hC, 32'd3);
        write(4'h2, 32'd100);
        write(4'hF, 32'd1);
        pstart();
        chk("sw_commit_del", {16'd0, del}, 32'd100);
        chk("sw_commit_pt", {16'd0, point_idx}, 32'd0);
        chk("sw_commit_busy", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            pstart();
            chk("sw_del", {16'd0, del}, 32'(100 + 10 * (k / 2)));
            chk("sw_pt", {16'd0, point_idx}, 32'(k / 2));
            chk("sw_done", {31'd0, sweep_done}, (k == 6) ? 32'd1 : 32'd0);
            chk("sw_busy", {31'd0, busy}, (k == 6) ? 32'd0 : 32'd1);
        end
        tick();
        chk("sw_done_pulse", {31'd0, sweep_done}, 32'd0);
        pstart();
        chk("idle_pstart_del", {16'd0, del}, 32'd130);

        // Zero shots acts as one shot; delay wraps modulo 2^16
        write(4'hB, 32'd0);
        write(4'hC, 32'd2);
        write(4'h2, 32'd65530);
        write(4'hF, 32'd1);
        pstart();
        chk("wrap_commit_del", {16'd0, del}, 32'd65530);
        pstart();
        chk("wrap_del", {16'd0, del}, 32'd4);
        chk("wrap_pt", {16'd0, point_idx}, 32'd1);
        pstart();
        chk("wrap_del2", {16'd0, del}, 32'd14);
        chk("wrap_done", {31'd0, sweep_done}, 32'd1);

        // Commit during sweep aborts without sweep_done
        write(4'hC, 32'd5);
        write(4'hF, 32'd1);
        pstart();
        pstart();
        chk("abort_pre_pt", {16'd0, point_idx}, 32'd1);
        chk("abort_pre_del", {16'd0, del}, 32'd4);
        write(4'hF, 32'd0);
        chk("abort_armed_ready", {31'd0, wr_ready}, 32'd0);
        chk("abort_no_done", {31'd0, sweep_done}, 32'd0);
        pstart();
        chk("abort_del", {16'd0, del}, 32'd65530);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_commit_done", {31'd0, commit_done}, 32'd1);
        chk("abort_sweep_done", {31'd0, sweep_done}, 32'd0);

        // Reset asserted at sweep point 1 restores defaults immediately
        write(4'hF, 32'd1);
        pstart();
        pstart();
        chk("rst_sw_pt", {16'd0, point_idx}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstsw_del", {16'd0, del}, 32'd200);
        chk("rstsw_p1wid", {16'd0, p1wid}, 32'd30);
        chk("rstsw_pt", {16'd0, point_idx}, 32'd0);
        chk("rstsw_busy", {31'd0, busy}, 32'd0);
        chk("rstsw_done", {31'd0, sweep_done}, 32'd0);
        tick();
        reset = 1'b0;
        pstart();
        pstart();
        chk("post_rst_del", {16'd0, del}, 32'd200);
        chk("post_rst_done", {30'd0, commit_done, sweep_done}, 32'd0);
        chk("post_rst_ready", {31'd0, wr_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
